spi_slave_tx: RTL and testbench

//  SPI slave-side transmitter: the MISO return path for the 12-bit spi_master/spi_slave link.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_tx_if.sv | 45 ++++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_tx.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_tx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave transmitter slice.
// Holds the FSM state enum and the default frame width.
package spi_pkg;

    localparam int SPI_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_slave_tx_if.sv
// Bus bundle between local logic / SPI master and spi_slave_tx.
// Signals: tx_valid/tx_ready/din load handshake; sclk/cs/miso/miso_oe
// SPI pins; done/underrun/abort one-clk status pulses.
interface spi_slave_tx_if #(
    parameter int WIDTH = 12
);

    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] din;
    logic             sclk;
    logic             cs;
    logic             miso;
    logic             miso_oe;
    logic             done;
    logic             underrun;
    logic             abort;

    modport slave (
        input  tx_valid,
        input  din,
        input  sclk,
        input  cs,
        output tx_ready,
        output miso,
        output miso_oe,
        output done,
        output underrun,
        output abort
    );

    modport master (
        output tx_valid,
        output din,
        output sclk,
        output cs,
        input  tx_ready,
        input  miso,
        input  miso_oe,
        input  done,
        input  underrun,
        input  abort
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus edge pulses.
// Ports: clk, rst; d_i async input; lvl_o synced level;
// rise_o/fall_o one-clk pulses taken from the last two stages.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    // sync_q[0] is the newest sample, sync_q[STAGES-1] the oldest
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign lvl_o  = sync_q[STAGES-2];
    assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave MISO transmitter: one word per cs frame, LSB first.
// Ports: clk, rst (async, active high); bus = spi_slave_tx_if.slave
// carrying the load handshake, SPI pins and status pulses.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_tx_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b0)
    ) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.sclk),
        .lvl_o  (sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // cs idles high, so reset the chain high to avoid a false start
    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.cs),
        .lvl_o  (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    state_t           state_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic             miso_q;
    logic             oe_q;
    logic             done_q;
    logic             under_q;
    logic             abort_q;

    logic tx_ready;
    logic load;
    logic start;

    assign tx_ready = ~full_q;
    assign load     = bus.tx_valid & tx_ready;
    assign start    = (state_q == IDLE) & cs_fall;

    // A frame start empties the register; a same-clk load refills it
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (start) begin
            full_d = 1'b0;
        end
        if (load) begin
            hold_d = bus.din;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            under_q <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        shift_q <= full_q ? hold_q : '0;
                        miso_q  <= full_q & hold_q[0];
                        under_q <= ~full_q;
                        oe_q    <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    // final rise wins over a coincident cs rise
                    if (sclk_rise && cnt_q == CNT_LAST) begin
                        cnt_q   <= CNT_FULL;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cs_rise) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        oe_q    <= 1'b0;
                        miso_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (sclk_rise) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (sclk_fall) begin
                        shift_q <= shift_q >> 1;
                        miso_q  <= shift_q[1];
                    end
                end
                DONE: begin
                    // level, not edge: cs may have risen with the last sclk
                    if (cs_lvl) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                        miso_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.miso     = miso_q;
    assign bus.miso_oe  = oe_q;
    assign bus.done     = done_q;
    assign bus.underrun = under_q;
    assign bus.abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: loads words, plays SPI master
// frames and compares returned words and status pulses.
module tb_spi_slave_tx;

    localparam int W    = 12;
    localparam int HOLD = 4;

    logic clk;
    logic rst;

    spi_slave_tx_if #(.WIDTH(W)) bus ();

    spi_slave_tx #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;
    int n_done;
    int n_under;
    int n_abort;

    always @(negedge clk) begin
        if (bus.done)     n_done++;
        if (bus.underrun) n_under++;
        if (bus.abort)    n_abort++;
    end

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_cnt();
        n_done  = 0;
        n_under = 0;
        n_abort = 0;
    endtask

    task automatic load(input logic [W-1:0] w);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.din      = w;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.din      = '0;
    endtask

    // Master frame: nbits bits; cs raised at end when close is set
    task automatic frame(input int nbits, input bit close,
                         output logic [W-1:0] rx,
                         output bit oe_ok);
        rx    = '0;
        oe_ok = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat (HOLD) @(negedge clk);
            rx[i] = bus.miso;
            if (bus.miso_oe !== 1'b1) oe_ok = 1'b0;
            bus.sclk = 1'b1;
            repeat (HOLD) @(negedge clk);
            bus.sclk = 1'b0;
        end
        if (close) begin
            repeat (HOLD) @(negedge clk);
            bus.cs = 1'b1;
            repeat (HOLD + 4) @(negedge clk);
        end
    endtask

    logic [W-1:0] rx;
    logic [W-1:0] w;
    bit           ok;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clear_cnt();
        bus.tx_valid = 1'b0;
        bus.din      = '0;
        bus.sclk     = 1'b0;
        bus.cs       = 1'b1;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("rst_miso",  32'(bus.miso),     32'd0);
        check_eq("rst_oe",    32'(bus.miso_oe),  32'd0);
        check_eq("rst_done",  32'(bus.done),     32'd0);
        check_eq("rst_under", 32'(bus.underrun), 32'd0);
        check_eq("rst_abort", 32'(bus.abort),    32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: basic word
        clear_cnt();
        load(12'hA5C);
        check_eq("t1_ready_lo", 32'(bus.tx_ready), 32'd0);
        frame(W, 1'b1, rx, ok);
        check_eq("t1_rx",    32'(rx),       32'hA5C);
        check_eq("t1_oe",    32'(ok),       32'd1);
        check_eq("t1_done",  32'(n_done),   32'd1);
        check_eq("t1_under", 32'(n_under),  32'd0);
        check_eq("t1_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("t1_oe_off", 32'(bus.miso_oe), 32'd0);

        // 2: underrun
        clear_cnt();
        frame(W, 1'b1, rx, ok);
        check_eq("t2_rx",    32'(rx),      32'h000);
        check_eq("t2_under", 32'(n_under), 32'd1);
        check_eq("t2_done",  32'(n_done),  32'd1);

        // 3: load during a frame
        clear_cnt();
        load(12'h123);
        fork
            frame(W, 1'b1, rx, ok);
            begin
                repeat (20) @(negedge clk);
                load(12'h456);
                check_eq("t3_ready_mid", 32'(bus.tx_ready), 32'd0);
            end
        join
        check_eq("t3_rx1",   32'(rx),           32'h123);
        check_eq("t3_ready", 32'(bus.tx_ready), 32'd0);
        frame(W, 1'b1, rx, ok);
        check_eq("t3_rx2",   32'(rx),           32'h456);
        check_eq("t3_done",  32'(n_done),       32'd2);
        check_eq("t3_under", 32'(n_under),      32'd0);
        check_eq("t3_ready2", 32'(bus.tx_ready), 32'd1);

        // 4: abort after 5 bits
        clear_cnt();
        load(12'hFFF);
        frame(5, 1'b1, rx, ok);
        check_eq("t4_rx5",   32'(rx),          32'h01F);
        check_eq("t4_abort", 32'(n_abort),     32'd1);
        check_eq("t4_done",  32'(n_done),      32'd0);
        check_eq("t4_oe",    32'(bus.miso_oe), 32'd0);
        frame(W, 1'b1, rx, ok);
        check_eq("t4_rx",    32'(rx),          32'h000);
        check_eq("t4_under", 32'(n_under),     32'd1);

        // 5: reset mid-frame
        clear_cnt();
        load(12'h0F0);
        frame(6, 1'b0, rx, ok);
        check_eq("t5_oe_pre", 32'(bus.miso_oe), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_oe",    32'(bus.miso_oe),  32'd0);
        check_eq("t5_miso",  32'(bus.miso),     32'd0);
        check_eq("t5_ready", 32'(bus.tx_ready), 32'd1);
        bus.cs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("t5_done",  32'(n_done), 32'd0);
        frame(W, 1'b1, rx, ok);
        check_eq("t5_rx",    32'(rx),      32'h000);
        check_eq("t5_under", 32'(n_under), 32'd1);
        check_eq("t5_done2", 32'(n_done),  32'd1);

        // 6: minimum phase hold, random words
        clear_cnt();
        for (int k = 0; k < 20; k++) begin
            w = W'($urandom);
            load(w);
            frame(W, 1'b1, rx, ok);
            check_eq($sformatf("t6_rx%0d", k), 32'(rx), 32'(w));
        end
        check_eq("t6_done",  32'(n_done),  32'd20);
        check_eq("t6_under", 32'(n_under), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
